uart_rx_responder: RTL and testbench
====================================

Name: uart_rx_responder

Overview:
- Serial-to-byte receive path for custom-Verilog UART I/O on the 50 MHz board clock.
- Deserialises 8N1 frames from UART_RXD into a one-byte holding buffer.
- Returns bytes to the HLS-generated core over the start/finish/return call interface.
- The byte-receive counterpart of the existing send path; sits beside main in the top level and drives UART_BYTE_IN and UART_RESPONSE[1].

Parameters:
- CLKS_PER_BIT, 434, clock cycles per bit (50 MHz / 115200 baud); must be >= 4.
- CNT_W, 16, width of the bit-timing counter; must satisfy 2^CNT_W > CLKS_PER_BIT.

Ports:
- clk  input  1  system clock; all logic on the rising edge.
- reset  input  1  asynchronous, active-low reset. Any logic that uses it must treat reset==0 as reset asserted.
- start  input  1  one-cycle request from the core for the next byte.
- finish  output  1  one-cycle pulse; return is valid in the same cycle.
- return  output  8  received byte, held stable until the next finish.
- clear_err  input  1  clears the sticky error flags.
- framing_err  output  1  sticky; set when a stop bit is sampled low.
- overrun  output  1  sticky; set when a byte completes while the buffer is already full.
- UART_RXD  input  1  asynchronous serial line; idles high.

Behaviour:
- Reset (reset==0, asynchronous):
  - finish=0, return=8'h00, framing_err=0, overrun=0.
  - Holding buffer empty, request not armed, receiver FSM in IDLE, synchroniser flops preset to 1.
- UART_RXD passes through a two-flop synchroniser before any use. All sample timing below refers to the synchronised signal rxs.
- Receiver FSM (runs independently of start):
  - IDLE: a falling edge of rxs (previous sample 1, current 0) -> START, counter=0.
  - START: at counter==CLKS_PER_BIT/2 (integer divide), sample rxs.
    - rxs==0 -> DATA, bit index=0, counter=0.
    - rxs==1 -> IDLE (glitch rejected; no flags change).
  - DATA: each time counter reaches CLKS_PER_BIT-1, sample rxs into shift[bit index] (LSB first) and reset counter. After bit 7 -> STOP.
  - STOP: at counter==CLKS_PER_BIT-1, sample rxs.
    - rxs==1 -> byte completes, go to IDLE.
    - rxs==0 -> set framing_err, discard the byte, go to BREAK.
  - BREAK: stay until rxs==1, then IDLE. No start edge is accepted while in BREAK.
- Holding buffer:
  - On byte completion with the buffer empty, load the byte and mark it full.
  - On byte completion with the buffer full, drop the new byte, keep the old one, and set overrun.
- Request handshake:
  - start sets an armed flag. A start while already armed is ignored (no queuing).
  - When armed and the buffer is full:
    - next cycle finish=1 and return=buffered byte;
    - armed and full are both cleared.
  - Latency: if the buffer is full when start is sampled, finish occurs exactly 1 cycle after start. Otherwise finish occurs 1 cycle after byte completion.
  - If byte completion and start occur in the same cycle with the buffer empty, finish occurs on the following cycle with that byte.
  - A byte completing in the same cycle finish is issued sees the buffer as empty and is loaded with no overrun.
- Errors:
  - clear_err=1 clears framing_err and overrun on the next edge.
  - If clear_err and a set condition coincide, set wins.
- Reset asserted mid-frame or mid-request: everything returns to reset state immediately. A partial frame is lost; after reset the receiver waits for a fresh falling edge.

Decomposition:
- Shared package (uart_pkg):
  - FSM state encodings IDLE/START/DATA/STOP/BREAK as 3-bit localparams;
  - UART_DATA_BITS=8;
  - default CLKS_PER_BIT=434. The send path uses the same value, so both sides agree.
- One natural sub-module: uart_rx_sync, the two-flop synchroniser with preset-to-1 on reset and registered falling-edge detect output.

Test Plan (CLKS_PER_BIT=16 in simulation):
- Arm, then send 8'hA5 (frame 0,1,0,1,0,0,1,0,1,1) -> finish is one 1-cycle pulse with return=8'hA5 one cycle after the stop-bit sample; no flags set.
- Send 8'h3C with no start, wait 200 cycles, pulse start -> finish exactly 1 cycle after start, return=8'h3C.
- Send 8'h11 then 8'h22 back-to-back without start, then start -> return=8'h11, overrun=1. A second start with no further traffic produces no finish.
- Send 8'h55 with stop bit held low for 3 bit times, then a valid 8'h66 -> framing_err=1, 8'h55 never returned, next finish returns 8'h66. clear_err then drops framing_err to 0.
- Low glitch of 4 cycles on UART_RXD -> no finish, no flags, FSM back in IDLE; a following 8'h0F is received correctly.
- Assert reset (0) during bit 4 of a frame, release it, then send 8'hF0 -> all outputs 0 during reset; next finish returns 8'hF0 with no stale data.

Source files
------------

// File: rtl/uart_pkg.sv
// ============================================================================
//  uart_pkg : shared UART constants and receiver state encodings
//  Rev 1.0  : initial release
// ============================================================================
`default_nettype none

package uart_pkg;

    localparam int UART_DATA_BITS    = 8;
    localparam int UART_CLKS_PER_BIT = 434;  // 50 MHz / 115200 baud, shared with the send path

    localparam logic [2:0] RX_IDLE  = 3'd0;
    localparam logic [2:0] RX_START = 3'd1;
    localparam logic [2:0] RX_DATA  = 3'd2;
    localparam logic [2:0] RX_STOP  = 3'd3;
    localparam logic [2:0] RX_BREAK = 3'd4;

    typedef enum logic [2:0] {
        S_IDLE  = RX_IDLE,
        S_START = RX_START,
        S_DATA  = RX_DATA,
        S_STOP  = RX_STOP,
        S_BREAK = RX_BREAK
    } rx_state_e;

endpackage

`default_nettype wire

// File: rtl/uart_rx_sync.sv
// ============================================================================
//  uart_rx_sync : two-flop synchroniser for the serial line, preset to idle
//                 high, with a registered falling-edge detect
//  Rev 1.0      : initial release
// ============================================================================
`default_nettype none

module uart_rx_sync (
    input  logic clk,
    input  logic reset,
    input  logic rxd_i,
    output logic rxs_o,
    output logic fall_o
);

    logic meta_q;
    logic sync_q;
    logic fall_q;

    // fall_q is aligned with the first low cycle of sync_q
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            meta_q <= 1'b1;
            sync_q <= 1'b1;
            fall_q <= 1'b0;
        end else begin
            meta_q <= rxd_i;
            sync_q <= meta_q;
            fall_q <= sync_q & ~meta_q;
        end
    end

    assign rxs_o  = sync_q;
    assign fall_o = fall_q;

endmodule

`default_nettype wire

// File: rtl/uart_rx_responder.sv
// ============================================================================
//  uart_rx_responder : 8N1 UART receiver with one-byte holding buffer and a
//                      start/finish/return call interface for the HLS core
//  Rev 1.0           : initial release
// ============================================================================
`default_nettype none

module uart_rx_responder
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = UART_CLKS_PER_BIT,
    parameter int CNT_W        = 16
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      start,
    output logic                      finish,
    output logic [UART_DATA_BITS-1:0] return_o,
    input  logic                      clear_err,
    output logic                      framing_err,
    output logic                      overrun,
    input  logic                      UART_RXD
);

    localparam logic [CNT_W-1:0] C_HALF     = CNT_W'(CLKS_PER_BIT / 2);
    localparam logic [CNT_W-1:0] C_LAST     = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [2:0]       C_IDX_LAST = 3'(UART_DATA_BITS - 1);

    logic w_rxs;
    logic w_fall;

    uart_rx_sync u_sync (
        .clk    (clk),
        .reset  (reset),
        .rxd_i  (UART_RXD),
        .rxs_o  (w_rxs),
        .fall_o (w_fall)
    );

    rx_state_e                 state_q, state_d;
    logic [CNT_W-1:0]          cnt_q, cnt_d;
    logic [2:0]                idx_q, idx_d;
    logic [UART_DATA_BITS-1:0] shift_q, shift_d;
    logic [UART_DATA_BITS-1:0] buf_q, buf_d;
    logic [UART_DATA_BITS-1:0] ret_q, ret_d;
    logic                      full_q, full_d;
    logic                      armed_q, armed_d;
    logic                      finish_q, finish_d;
    logic                      ferr_q, ferr_d;
    logic                      ovr_q, ovr_d;

    logic w_done;
    logic w_ferr_set;
    logic w_armed;
    logic w_fire;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            idx_q    <= '0;
            shift_q  <= '0;
            buf_q    <= '0;
            ret_q    <= '0;
            full_q   <= 1'b0;
            armed_q  <= 1'b0;
            finish_q <= 1'b0;
            ferr_q   <= 1'b0;
            ovr_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            idx_q    <= idx_d;
            shift_q  <= shift_d;
            buf_q    <= buf_d;
            ret_q    <= ret_d;
            full_q   <= full_d;
            armed_q  <= armed_d;
            finish_q <= finish_d;
            ferr_q   <= ferr_d;
            ovr_q    <= ovr_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q + CNT_W'(1);
        idx_d      = idx_q;
        shift_d    = shift_q;
        w_done     = 1'b0;
        w_ferr_set = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                cnt_d = '0;
                if (w_fall) state_d = S_START;
            end
            S_START: begin
                if (cnt_q == C_HALF) begin
                    cnt_d   = '0;
                    idx_d   = '0;
                    state_d = w_rxs ? S_IDLE : S_DATA;
                end
            end
            S_DATA: begin
                if (cnt_q == C_LAST) begin
                    cnt_d          = '0;
                    shift_d[idx_q] = w_rxs;
                    idx_d          = idx_q + 3'd1;
                    if (idx_q == C_IDX_LAST) state_d = S_STOP;
                end
            end
            S_STOP: begin
                if (cnt_q == C_LAST) begin
                    cnt_d = '0;
                    if (w_rxs) begin
                        w_done  = 1'b1;
                        state_d = S_IDLE;
                    end else begin
                        w_ferr_set = 1'b1;
                        state_d    = S_BREAK;
                    end
                end
            end
            S_BREAK: begin
                cnt_d = '0;
                if (w_rxs) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // A completing byte counts as available this cycle so finish follows it by one clock
    assign w_armed = armed_q | start;
    assign w_fire  = w_armed & (full_q | w_done);

    always_comb begin
        armed_d  = w_armed & ~w_fire;
        finish_d = w_fire;
        full_d   = full_q;
        buf_d    = buf_q;
        ret_d    = ret_q;
        if (w_fire) begin
            ret_d  = full_q ? buf_q : shift_q;
            full_d = full_q & w_done;
            if (full_q & w_done) buf_d = shift_q;
        end else if (w_done && !full_q) begin
            full_d = 1'b1;
            buf_d  = shift_q;
        end
        ferr_d = w_ferr_set | (ferr_q & ~clear_err);
        ovr_d  = (w_done & full_q & ~w_fire) | (ovr_q & ~clear_err);
    end

    assign finish      = finish_q;
    assign return_o    = ret_q;
    assign framing_err = ferr_q;
    assign overrun     = ovr_q;

endmodule

`default_nettype wire

// File: tb/tb_uart_rx_responder.sv
// ============================================================================
//  tb_uart_rx_responder : self-checking bench for uart_rx_responder
//  Rev 1.0              : initial release
// ============================================================================
`default_nettype none

module tb_uart_rx_responder;

    localparam int CPB = 16;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic       finish;
    logic [7:0] ret;
    logic       clear_err;
    logic       framing_err;
    logic       overrun;
    logic       rxd;

    always #5 clk = ~clk;

    uart_rx_responder #(.CLKS_PER_BIT(CPB), .CNT_W(8)) dut (
        .clk         (clk),
        .reset       (rst_n),
        .start       (start),
        .finish      (finish),
        .return_o    (ret),
        .clear_err   (clear_err),
        .framing_err (framing_err),
        .overrun     (overrun),
        .UART_RXD    (rxd)
    );

    int         vectors     = 0;
    int         miscompares = 0;
    logic [7:0] got_q[$];

    always @(negedge clk) if (finish === 1'b1) got_q.push_back(ret);

    typedef struct {
        bit         send;
        logic [7:0] data;
        int         stop_low;
        bit         pre;
        bit         post;
        int         idle;
        bit         clr;
        int         exp_n;
        logic [7:0] exp_ret;
        bit         exp_post_fin;
        bit         exp_ferr;
        bit         exp_ovr;
    } vec_t;

    vec_t tbl[7];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input logic [7:0] d, input int stop_low);
        rxd = 1'b0;
        tick(CPB);
        for (int i = 0; i < 8; i++) begin
            rxd = d[i];
            tick(CPB);
        end
        if (stop_low > 0) begin
            rxd = 1'b0;
            tick(CPB * stop_low);
        end
        rxd = 1'b1;
        tick(CPB + 4);
    endtask

    task automatic pulse_start(output logic fin);
        start = 1'b1;
        tick();
        fin   = finish;
        start = 1'b0;
    endtask

    task automatic check_idle_outputs(input string tag);
        chk({tag, " finish"}, 32'(finish), 32'd0);
        chk({tag, " return"}, 32'(ret), 32'd0);
        chk({tag, " framing_err"}, 32'(framing_err), 32'd0);
        chk({tag, " overrun"}, 32'(overrun), 32'd0);
    endtask

    // Transaction-level reference: holding buffer, armed request, sticky flags
    bit         m_full, m_armed, m_ferr, m_ovr;
    logic [7:0] m_buf, m_last;
    logic [7:0] exp_q[$];

    initial begin
        logic       f;
        logic [7:0] d;
        bit         bad, pre, clr;

        //                 send data  stpl pre post idle clr n  ret   pf ferr ovr
        tbl[0] = '{1'b1, 8'hA5, 0, 1'b1, 1'b0,   0, 1'b0, 1, 8'hA5, 1'b0, 1'b0, 1'b0};
        tbl[1] = '{1'b1, 8'h3C, 0, 1'b0, 1'b1, 200, 1'b0, 1, 8'h3C, 1'b1, 1'b0, 1'b0};
        tbl[2] = '{1'b1, 8'h11, 0, 1'b0, 1'b0,   0, 1'b0, 0, 8'h3C, 1'b0, 1'b0, 1'b0};
        tbl[3] = '{1'b1, 8'h22, 0, 1'b0, 1'b1,  20, 1'b0, 1, 8'h11, 1'b1, 1'b0, 1'b1};
        tbl[4] = '{1'b0, 8'h00, 0, 1'b0, 1'b1,  20, 1'b0, 0, 8'h11, 1'b0, 1'b0, 1'b1};
        tbl[5] = '{1'b1, 8'h55, 3, 1'b0, 1'b0,   0, 1'b0, 0, 8'h11, 1'b0, 1'b1, 1'b1};
        tbl[6] = '{1'b1, 8'h66, 0, 1'b0, 1'b0,   0, 1'b1, 1, 8'h66, 1'b0, 1'b0, 1'b0};

        rst_n = 1'b0; start = 1'b0; clear_err = 1'b0; rxd = 1'b1;
        tick(3);
        check_idle_outputs("reset");
        rst_n = 1'b1;
        tick(5);

        for (int i = 0; i < 7; i++) begin
            got_q.delete();
            if (tbl[i].pre) pulse_start(f);
            if (tbl[i].send) send_frame(tbl[i].data, tbl[i].stop_low);
            if (tbl[i].post) begin
                tick(tbl[i].idle);
                pulse_start(f);
                chk($sformatf("vec%0d finish after start", i), 32'(f), 32'(tbl[i].exp_post_fin));
            end
            tick(2);
            if (tbl[i].clr) begin
                clear_err = 1'b1;
                tick();
                clear_err = 1'b0;
            end
            chk($sformatf("vec%0d finish count", i), 32'(got_q.size()), 32'(tbl[i].exp_n));
            if (got_q.size() > 0)
                chk($sformatf("vec%0d returned byte", i), 32'(got_q[$]), 32'(tbl[i].exp_ret));
            chk($sformatf("vec%0d return held", i), 32'(ret), 32'(tbl[i].exp_ret));
            chk($sformatf("vec%0d framing_err", i), 32'(framing_err), 32'(tbl[i].exp_ferr));
            chk($sformatf("vec%0d overrun", i), 32'(overrun), 32'(tbl[i].exp_ovr));
        end

        // Short low glitch must be rejected, then a normal frame received
        got_q.delete();
        rxd = 1'b0;
        tick(4);
        rxd = 1'b1;
        tick(40);
        chk("glitch finish count", 32'(got_q.size()), 32'd0);
        chk("glitch framing_err", 32'(framing_err), 32'd0);
        chk("glitch overrun", 32'(overrun), 32'd0);
        pulse_start(f);
        chk("glitch arm no finish", 32'(f), 32'd0);
        send_frame(8'h0F, 0);
        tick(2);
        chk("post-glitch finish count", 32'(got_q.size()), 32'd1);
        if (got_q.size() > 0) chk("post-glitch byte", 32'(got_q[$]), 32'h0F);

        // Reset in the middle of bit 4 with a request armed
        got_q.delete();
        pulse_start(f);
        d = 8'h99;
        rxd = 1'b0;
        tick(CPB);
        for (int i = 0; i < 4; i++) begin
            rxd = d[i];
            tick(CPB);
        end
        rxd = d[4];
        tick(CPB / 2);
        rst_n = 1'b0;
        #1;
        check_idle_outputs("mid-frame reset");
        rxd = 1'b1;
        tick(3);
        rst_n = 1'b1;
        tick(20);
        send_frame(8'hF0, 0);
        tick(2);
        chk("after reset no armed finish", 32'(got_q.size()), 32'd0);
        pulse_start(f);
        chk("after reset start latency", 32'(f), 32'd1);
        chk("after reset byte", 32'(ret), 32'hF0);

        // Randomised traffic against the transaction-level model
        rst_n = 1'b0;
        tick(2);
        rst_n = 1'b1;
        tick(5);
        got_q.delete(); exp_q.delete();
        m_full = 0; m_armed = 0; m_ferr = 0; m_ovr = 0; m_buf = '0; m_last = '0;
        for (int it = 0; it < 20; it++) begin
            d   = 8'($urandom);
            bad = ($urandom_range(0, 4) == 0);
            pre = ($urandom_range(0, 1) == 1);
            clr = ($urandom_range(0, 3) == 0);
            if (pre) begin
                pulse_start(f);
                chk($sformatf("rand%0d start latency", it), 32'(f), 32'(m_full));
                if (!m_armed) begin
                    if (m_full) begin
                        exp_q.push_back(m_buf);
                        m_last = m_buf;
                        m_full = 0;
                    end else begin
                        m_armed = 1;
                    end
                end
            end
            send_frame(d, bad ? 2 : 0);
            if (bad) m_ferr = 1;
            else if (m_armed) begin
                exp_q.push_back(d);
                m_last  = d;
                m_armed = 0;
            end else if (m_full) m_ovr = 1;
            else begin
                m_full = 1;
                m_buf  = d;
            end
            tick(2);
            if (clr) begin
                clear_err = 1'b1;
                tick();
                clear_err = 1'b0;
                m_ferr = 0;
                m_ovr  = 0;
            end
            chk($sformatf("rand%0d finish count", it), 32'(got_q.size()), 32'(exp_q.size()));
            while (got_q.size() > 0 && exp_q.size() > 0)
                chk($sformatf("rand%0d returned byte", it), 32'(got_q.pop_front()), 32'(exp_q.pop_front()));
            got_q.delete(); exp_q.delete();
            chk($sformatf("rand%0d return held", it), 32'(ret), 32'(m_last));
            chk($sformatf("rand%0d framing_err", it), 32'(framing_err), 32'(m_ferr));
            chk($sformatf("rand%0d overrun", it), 32'(overrun), 32'(m_ovr));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

`default_nettype wire
